// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter.
//   arb_state_e : arbiter FSM state encoding
//   FUNC3_WORD  : access-size code used for every instruction fetch
//   ctr_width   : width helper for small saturating counters
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_ACC  = 3'd1,
    D_ACC  = 3'd2,
    I_DONE = 3'd3,
    D_DONE = 3'd4
  } arb_state_e;

  localparam logic [2:0] FUNC3_WORD = 3'b010;

  // Bits needed to hold 0..max_val, never fewer than min_w.
  function automatic int ctr_width(input int max_val, input int min_w);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return (w < min_w) ? min_w : w;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_counter.sv
// Fetch-starvation counter for the memory arbiter.
// Counts data grants made while a fetch is waiting and saturates at LIMIT.
// It clears on a fetch grant, or on any idle cycle with no fetch pending.
//   clk_i, rst_i : clock, synchronous active-high reset
//   d_grant_i    : data port granted this cycle
//   i_grant_i    : fetch port granted this cycle
//   i_pend_i     : fetch request currently asserted
//   idle_i       : arbiter is in IDLE
//   at_limit_o   : count has reached LIMIT (fetch must win the next tie)
module starve_counter
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_grant_i,
  input  logic i_grant_i,
  input  logic i_pend_i,
  input  logic idle_i,
  output logic at_limit_o
);

  localparam int W = ctr_width(LIMIT, 3);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_grant_i || (idle_i && !i_pend_i)) begin
      cnt_d = '0;
    end else if (d_grant_i && i_pend_i && (cnt_q < W'(LIMIT))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == W'(LIMIT));

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one memory between instruction fetch (I) and
// data load/store (D). Data wins ties unless fetch has been starved for
// STARVE_LIMIT consecutive data grants. Each access is ACC (memory strobes
// driven from a snapshot taken at grant), then one DONE cycle in which the
// requesting port's busywait drops.
//   CLK, RESET             : clock, synchronous active-high reset
//   I_READ/I_ADDRESS       : fetch request; I_READDATA/I_BUSYWAIT response
//   D_READ/D_WRITE/...     : load/store request; D_READDATA/D_BUSYWAIT response
//   M_*                    : shared memory strobes, address, data, size code
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4,
  parameter int MIN_ACC_CYCLES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I_READ,
  input  logic [31:0] I_ADDRESS,
  output logic [31:0] I_READDATA,
  output logic        I_BUSYWAIT,
  input  logic        D_READ,
  input  logic        D_WRITE,
  input  logic [31:0] D_ADDRESS,
  input  logic [31:0] D_WRITEDATA,
  input  logic [2:0]  D_FUNC3,
  output logic [31:0] D_READDATA,
  output logic        D_BUSYWAIT,
  output logic        M_READ,
  output logic        M_WRITE,
  output logic [31:0] M_ADDRESS,
  output logic [31:0] M_WRITEDATA,
  output logic [2:0]  M_FUNC3,
  input  logic [31:0] M_READDATA,
  input  logic        M_BUSYWAIT
);

  localparam int ACC_W = ctr_width(MIN_ACC_CYCLES, 1);

  arb_state_e        state_q, state_d;
  logic              i_pend, d_pend;
  logic              grant_i, grant_d;
  logic              starve_at_limit;
  logic              in_acc, acc_done;
  logic [ACC_W-1:0]  acc_cnt_q, acc_cnt_d;

  // Request snapshot: the memory sees only these while in ACC.
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [2:0]        func3_q, func3_d;
  logic              wr_q, wr_d;

  logic [31:0]       i_rdata_q, i_rdata_d;
  logic [31:0]       d_rdata_q, d_rdata_d;

  assign i_pend = I_READ;
  assign d_pend = D_READ | D_WRITE;
  assign in_acc = (state_q == I_ACC) || (state_q == D_ACC);

  // M_BUSYWAIT is not trusted until the memory has had MIN_ACC_CYCLES
  // cycles to raise it.
  assign acc_done = in_acc && (acc_cnt_q >= ACC_W'(MIN_ACC_CYCLES)) && !M_BUSYWAIT;

  // Next-state and grant decision
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_pend && i_pend) begin
          if (starve_at_limit) grant_i = 1'b1;
          else                 grant_d = 1'b1;
        end else if (d_pend) begin
          grant_d = 1'b1;
        end else if (i_pend) begin
          grant_i = 1'b1;
        end
        if (grant_i) state_d = I_ACC;
        if (grant_d) state_d = D_ACC;
      end
      I_ACC:   if (acc_done) state_d = I_DONE;
      D_ACC:   if (acc_done) state_d = D_DONE;
      I_DONE:  state_d = IDLE;
      D_DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Snapshot, access-cycle counter and read-data capture
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    func3_d   = func3_q;
    wr_d      = wr_q;
    acc_cnt_d = acc_cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    if (grant_i) begin
      addr_d  = I_ADDRESS;
      wdata_d = '0;
      func3_d = FUNC3_WORD;
      wr_d    = 1'b0;
    end else if (grant_d) begin
      addr_d  = D_ADDRESS;
      wdata_d = D_WRITEDATA;
      func3_d = D_FUNC3;
      wr_d    = D_WRITE;
    end

    if (grant_i || grant_d) begin
      acc_cnt_d = '0;
    end else if (in_acc && (acc_cnt_q < ACC_W'(MIN_ACC_CYCLES))) begin
      acc_cnt_d = acc_cnt_q + ACC_W'(1);
    end

    if (acc_done && (state_q == I_ACC)) i_rdata_d = M_READDATA;
    // A store completes without touching the load result register.
    if (acc_done && (state_q == D_ACC) && !wr_q) d_rdata_d = M_READDATA;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      acc_cnt_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Snapshot is only observed while in ACC, so it needs no reset.
  always_ff @(posedge CLK) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    func3_q <= func3_d;
    wr_q    <= wr_d;
  end

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .d_grant_i  (grant_d),
    .i_grant_i  (grant_i),
    .i_pend_i   (i_pend),
    .idle_i     (state_q == IDLE),
    .at_limit_o (starve_at_limit)
  );

  assign M_READ      = (state_q == I_ACC) || ((state_q == D_ACC) && !wr_q);
  assign M_WRITE     = (state_q == D_ACC) && wr_q;
  assign M_ADDRESS   = addr_q;
  assign M_WRITEDATA = wdata_q;
  assign M_FUNC3     = func3_q;

  assign I_READDATA  = i_rdata_q;
  assign D_READDATA  = d_rdata_q;

  // Stall rises combinationally with the request and drops only in DONE.
  assign I_BUSYWAIT  = !RESET && i_pend && (state_q != I_DONE);
  assign D_BUSYWAIT  = !RESET && d_pend && (state_q != D_DONE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    int          lat;
  } rsp_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I_READ;
  logic [31:0] I_ADDRESS;
  logic [31:0] I_READDATA;
  logic        I_BUSYWAIT;
  logic        D_READ, D_WRITE;
  logic [31:0] D_ADDRESS, D_WRITEDATA;
  logic [2:0]  D_FUNC3;
  logic [31:0] D_READDATA;
  logic        D_BUSYWAIT;
  logic        M_READ, M_WRITE;
  logic [31:0] M_ADDRESS, M_WRITEDATA;
  logic [2:0]  M_FUNC3;
  logic [31:0] M_READDATA;
  logic        M_BUSYWAIT;

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   mem_cyc = 0;
  int   wait_cycles = 0;

  bus_t mem_q[$];
  rsp_t i_q[$];
  rsp_t d_q[$];

  mem_arbiter #(.STARVE_LIMIT(4), .MIN_ACC_CYCLES(1)) dut (
    .CLK(CLK), .RESET(RESET),
    .I_READ(I_READ), .I_ADDRESS(I_ADDRESS), .I_READDATA(I_READDATA), .I_BUSYWAIT(I_BUSYWAIT),
    .D_READ(D_READ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_WRITEDATA(D_WRITEDATA),
    .D_FUNC3(D_FUNC3), .D_READDATA(D_READDATA), .D_BUSYWAIT(D_BUSYWAIT),
    .M_READ(M_READ), .M_WRITE(M_WRITE), .M_ADDRESS(M_ADDRESS), .M_WRITEDATA(M_WRITEDATA),
    .M_FUNC3(M_FUNC3), .M_READDATA(M_READDATA), .M_BUSYWAIT(M_BUSYWAIT)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory model: busy for the first wait_cycles cycles of each strobe burst.
  always @(posedge CLK) mem_cyc <= (M_READ | M_WRITE) ? mem_cyc + 1 : 0;
  assign M_BUSYWAIT = (M_READ | M_WRITE) && (mem_cyc < wait_cycles);
  assign M_READDATA = (M_ADDRESS == 32'h40) ? 32'h00500093 : {M_ADDRESS[15:0], 16'hC0DE};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_event(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic push_bus(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [2:0] f3);
    bus_t b;
    b.rd = rd; b.wr = wr; b.addr = addr; b.wdata = wdata; b.f3 = f3;
    mem_q.push_back(b);
  endtask

  task automatic push_i(input logic [31:0] data, input int lat);
    rsp_t r;
    r.data = data; r.lat = lat;
    i_q.push_back(r);
  endtask

  task automatic push_d(input logic [31:0] data, input int lat);
    rsp_t r;
    r.data = data; r.lat = lat;
    d_q.push_back(r);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Holds I_READ across n fetches, moving to the next address after each DONE.
  task automatic drive_i(input logic [31:0] addrs [8], input int n);
    int t;
    I_READ = 1'b1;
    I_ADDRESS = addrs[0];
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (I_BUSYWAIT && t < 200);
      if (I_BUSYWAIT) fail_event("i_timeout");
      tick();
      if (k + 1 < n) I_ADDRESS = addrs[k + 1];
      else           I_READ = 1'b0;
    end
  endtask

  task automatic drive_d(input logic rd, input logic wr, input logic [31:0] addrs [8],
                         input int n, input logic [31:0] wdata, input logic [2:0] f3);
    int t;
    D_READ = rd;
    D_WRITE = wr;
    D_WRITEDATA = wdata;
    D_FUNC3 = f3;
    D_ADDRESS = addrs[0];
    for (int k = 0; k < n; k++) begin
      t = 0;
      do begin
        @(negedge CLK);
        t++;
      end while (D_BUSYWAIT && t < 200);
      if (D_BUSYWAIT) fail_event("d_timeout");
      tick();
      if (k + 1 < n) D_ADDRESS = addrs[k + 1];
      else begin
        D_READ = 1'b0;
        D_WRITE = 1'b0;
      end
    end
  endtask

  // Monitor: pops expectations when the bus starts a transaction or a port completes.
  initial begin
    bus_t        eb;
    rsp_t        er;
    logic        strobe, d_req, i_done, d_done;
    logic        strobe_prev, i_req_prev, d_req_prev, i_done_prev, d_done_prev;
    logic [31:0] cur_addr;
    logic [2:0]  cur_f3;
    logic        cur_wr;
    int          i_start, d_start;
    strobe_prev = 0; i_req_prev = 0; d_req_prev = 0; i_done_prev = 0; d_done_prev = 0;
    cur_addr = '0; cur_f3 = '0; cur_wr = 0; i_start = 0; d_start = 0;
    forever begin
      @(negedge CLK);
      if (RESET) begin
        strobe_prev = 0; i_req_prev = 0; d_req_prev = 0; i_done_prev = 0; d_done_prev = 0;
      end else begin
        strobe = M_READ | M_WRITE;
        d_req  = D_READ | D_WRITE;
        if (I_READ && (!i_req_prev || i_done_prev)) i_start = cyc;
        if (d_req && (!d_req_prev || d_done_prev))  d_start = cyc;

        if (strobe && !strobe_prev) begin
          cur_addr = M_ADDRESS; cur_f3 = M_FUNC3; cur_wr = M_WRITE;
          if (mem_q.size() == 0) fail_event("bus_unexpected_transaction");
          else begin
            eb = mem_q.pop_front();
            check("bus_read",  M_READ,    eb.rd);
            check("bus_write", M_WRITE,   eb.wr);
            check("bus_addr",  M_ADDRESS, eb.addr);
            check("bus_func3", M_FUNC3,   eb.f3);
            if (eb.wr) check("bus_wdata", M_WRITEDATA, eb.wdata);
          end
        end else if (strobe) begin
          check("bus_addr_stable",  M_ADDRESS, cur_addr);
          check("bus_func3_stable", M_FUNC3,   cur_f3);
          check("bus_write_stable", M_WRITE,   cur_wr);
        end
        if (strobe && d_req)  check("d_busy_during_acc", D_BUSYWAIT, 1'b1);
        if (strobe && I_READ) check("i_busy_during_acc", I_BUSYWAIT, 1'b1);

        i_done = I_READ && !I_BUSYWAIT;
        d_done = d_req && !D_BUSYWAIT;
        if (i_done) begin
          if (i_q.size() == 0) fail_event("i_unexpected_completion");
          else begin
            er = i_q.pop_front();
            check("i_readdata", I_READDATA, er.data);
            if (er.lat >= 0) check("i_latency", cyc - i_start, er.lat);
          end
        end
        if (d_done) begin
          if (d_q.size() == 0) fail_event("d_unexpected_completion");
          else begin
            er = d_q.pop_front();
            check("d_readdata", D_READDATA, er.data);
            if (er.lat >= 0) check("d_latency", cyc - d_start, er.lat);
          end
        end
        strobe_prev = strobe; i_req_prev = I_READ; d_req_prev = d_req;
        i_done_prev = i_done; d_done_prev = d_done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    logic [31:0] ia [8];
    logic [31:0] da [8];
    for (int k = 0; k < 8; k++) begin
      ia[k] = '0;
      da[k] = '0;
    end

    RESET = 1'b1; I_READ = 1'b1; D_READ = 1'b1; D_WRITE = 1'b0;
    I_ADDRESS = 32'h40; D_ADDRESS = 32'h200; D_WRITEDATA = '0; D_FUNC3 = 3'b010;

    // Reset held with both requests asserted: no stalls, no strobes, zero data.
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      check("rst_i_busywait", I_BUSYWAIT, 1'b0);
      check("rst_d_busywait", D_BUSYWAIT, 1'b0);
      check("rst_m_read",     M_READ,     1'b0);
      check("rst_m_write",    M_WRITE,    1'b0);
      check("rst_i_readdata", I_READDATA, 32'h0);
      check("rst_d_readdata", D_READDATA, 32'h0);
    end
    tick();
    I_READ = 1'b0; D_READ = 1'b0; RESET = 1'b0;
    tick();

    // Lone fetch from 0x40, zero-wait memory.
    wait_cycles = 0;
    push_bus(1, 0, 32'h40, 32'h0, 3'b010);
    push_i(32'h00500093, 3);
    ia[0] = 32'h40;
    drive_i(ia, 1);
    tick();

    // Lone load from 0x200.
    push_bus(1, 0, 32'h200, 32'h0, 3'b100);
    push_d(32'h0200C0DE, 3);
    da[0] = 32'h200;
    drive_d(1, 0, da, 1, 32'h0, 3'b100);
    tick();

    // Fetch and store in the same cycle: store first, fetch after D_DONE->IDLE.
    push_bus(0, 1, 32'h100, 32'hDEADBEEF, 3'b010);
    push_bus(1, 0, 32'h44, 32'h0, 3'b010);
    push_d(32'h0200C0DE, 3);
    push_i(32'h0044C0DE, 7);
    ia[0] = 32'h44;
    da[0] = 32'h100;
    fork
      drive_i(ia, 1);
      drive_d(0, 1, da, 1, 32'hDEADBEEF, 3'b010);
    join
    tick();

    // Read and write both asserted: write wins, load result untouched.
    push_bus(0, 1, 32'h104, 32'h12345678, 3'b001);
    push_d(32'h0200C0DE, 3);
    da[0] = 32'h104;
    drive_d(1, 1, da, 1, 32'h12345678, 3'b001);
    tick();

    // Load with memory busy for 5 cycles.
    wait_cycles = 5;
    push_bus(1, 0, 32'h300, 32'h0, 3'b000);
    push_d(32'h0300C0DE, 7);
    da[0] = 32'h300;
    drive_d(1, 0, da, 1, 32'h0, 3'b000);
    wait_cycles = 0;
    tick();

    // Starvation: 4 loads, then the held fetch, then loads resume with a cleared count.
    for (int k = 0; k < 6; k++) da[k] = 32'h400 + 32'(4 * k);
    ia[0] = 32'h80; ia[1] = 32'h84;
    push_bus(1, 0, 32'h400, 32'h0, 3'b010);
    push_bus(1, 0, 32'h404, 32'h0, 3'b010);
    push_bus(1, 0, 32'h408, 32'h0, 3'b010);
    push_bus(1, 0, 32'h40C, 32'h0, 3'b010);
    push_bus(1, 0, 32'h80,  32'h0, 3'b010);
    push_bus(1, 0, 32'h410, 32'h0, 3'b010);
    push_bus(1, 0, 32'h414, 32'h0, 3'b010);
    push_bus(1, 0, 32'h84,  32'h0, 3'b010);
    push_d(32'h0400C0DE, -1); push_d(32'h0404C0DE, -1); push_d(32'h0408C0DE, -1);
    push_d(32'h040CC0DE, -1); push_d(32'h0410C0DE, -1); push_d(32'h0414C0DE, -1);
    push_i(32'h0080C0DE, -1); push_i(32'h0084C0DE, -1);
    fork
      drive_i(ia, 2);
      drive_d(1, 0, da, 6, 32'h0, 3'b010);
    join
    tick();

    // Reset during a slow store: back to IDLE, strobes low, both read registers cleared.
    wait_cycles = 5;
    push_bus(0, 1, 32'h500, 32'hCAFEF00D, 3'b010);
    D_WRITE = 1'b1; D_ADDRESS = 32'h500; D_WRITEDATA = 32'hCAFEF00D; D_FUNC3 = 3'b010;
    tick();
    tick();
    @(negedge CLK);
    check("pre_rst_m_write", M_WRITE, 1'b1);
    tick();
    RESET = 1'b1; D_WRITE = 1'b0;
    tick();
    RESET = 1'b0;
    @(negedge CLK);
    check("midrst_m_write",    M_WRITE,    1'b0);
    check("midrst_m_read",     M_READ,     1'b0);
    check("midrst_i_readdata", I_READDATA, 32'h0);
    check("midrst_d_readdata", D_READDATA, 32'h0);
    for (int k = 0; k < 2; k++) begin
      tick();
      @(negedge CLK);
      check("post_rst_m_write", M_WRITE, 1'b0);
      check("post_rst_m_read",  M_READ,  1'b0);
    end
    wait_cycles = 0;
    tick();

    check("bus_queue_drained", mem_q.size(), 0);
    check("i_queue_drained",   i_q.size(),   0);
    check("d_queue_drained",   d_q.size(),   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
